// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit.
//   PS_*           : PC step-select encodings driven toward the program counter
//   fetch_state_e  : fetch FSM states
//   fq_entry_t     : one fetch-queue entry (instruction word + its address)
package instr_fetch_unit_pkg;

  localparam logic [1:0] PS_HOLD   = 2'b00;
  localparam logic [1:0] PS_INC    = 2'b01;
  localparam logic [1:0] PS_LOAD   = 2'b10;
  localparam logic [1:0] PS_OFFSET = 2'b11;  // belongs to other PC users; never driven here

  typedef enum logic {
    FETCH = 1'b0,
    DROP  = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fq_entry_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bus bundle around the fetch unit: PC control, instruction-memory port,
// decode-side queue head and execute redirect.
//   master : the fetch unit's view
//   slave  : the surrounding PC / memory / decode / execute view
//
// Handshakes:
//   imem   : imem_req is held with imem_addr stable until the single-cycle
//            imem_ack; imem_rdata is valid only in the ack cycle.
//   decode : an entry transfers on a cycle where if_valid && if_ready;
//            if_valid never waits on if_ready. A redirect in the same
//            cycle overrides the transfer.
interface instr_fetch_unit_if;
  import instr_fetch_unit_pkg::*;

  logic [31:0] pc;
  logic [1:0]  ps;
  logic [31:0] pc_in;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_4;
  logic        redirect_valid;
  logic [31:0] redirect_target;

  modport master (
    input  pc,
    output ps, pc_in,
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    output if_valid, if_instr, if_pc, if_pc_4,
    input  if_ready,
    input  redirect_valid, redirect_target
  );

  modport slave (
    output pc,
    input  ps, pc_in,
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    input  if_valid, if_instr, if_pc, if_pc_4,
    output if_ready,
    output redirect_valid, redirect_target
  );

endinterface

// File: rtl/instr_fetch_unit_fetch_queue.sv
// Synchronous FIFO holding fetched {instr, pc} entries for decode.
//   clk, rst   : clock, asynchronous active-high reset
//   push/data  : write push_data at the tail
//   pop        : drop the head entry
//   flush      : empty the queue; wins over push and pop
//   head       : current head entry (valid when !empty)
//   count      : number of held entries
//   empty/full : occupancy flags
module fetch_queue #(
  parameter int DEPTH = 2,
  parameter int W     = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_q <= count_q + CW'(1);
      else if (!do_push && do_pop) count_q <= count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage between the program counter and decode.
//   clk, rst     : clock, asynchronous active-high reset
//   bus          : instr_fetch_unit_if.master (PC control, imem, decode, redirect)
//   dbg_state_o  : current fetch FSM state
//   dbg_count_o  : current fetch-queue occupancy
// FETCH issues a read at the current PC whenever the queue has room and
// advances the PC on each ack. A redirect that catches a read in flight
// moves to DROP, which keeps that read alive at its original address and
// throws its data away when the ack finally arrives.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  instr_fetch_unit_if.master     bus,
  output fetch_state_e           dbg_state_o,
  output logic [$clog2(DEPTH):0] dbg_count_o
);

  fetch_state_e state_q, state_d;
  logic [31:0]  drop_addr_q, drop_addr_d;
  logic [1:0]   ps;
  logic         req;
  logic [31:0]  addr;
  logic         q_push, q_pop, q_flush, q_empty, q_full;
  logic [$clog2(DEPTH):0] q_count;
  fq_entry_t    q_wdata, q_head;

  assign q_wdata = '{instr: bus.imem_rdata, pc: bus.pc};
  assign q_flush = bus.redirect_valid;
  assign q_pop   = !q_empty && bus.if_ready;

  fetch_queue #(.DEPTH(DEPTH), .W($bits(fq_entry_t))) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (q_push),
    .push_data (q_wdata),
    .pop       (q_pop),
    .flush     (q_flush),
    .head      (q_head),
    .count     (q_count),
    .empty     (q_empty),
    .full      (q_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FETCH;
      drop_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      drop_addr_q <= drop_addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    drop_addr_d = drop_addr_q;
    ps          = PS_HOLD;
    req         = 1'b0;
    addr        = bus.pc;
    q_push      = 1'b0;
    unique case (state_q)
      FETCH: begin
        // Room is judged on the current count only: a same-cycle pop does
        // not open a slot, keeping if_ready out of the request path.
        req = !q_full && !rst;
        if (bus.redirect_valid) begin
          // A read caught in flight must still be completed and discarded.
          if (req && !bus.imem_ack) begin
            state_d     = DROP;
            drop_addr_d = bus.pc;
          end
        end else if (req && bus.imem_ack) begin
          q_push = 1'b1;
          ps     = PS_INC;
        end
      end
      DROP: begin
        req  = !rst;
        addr = drop_addr_q;
        if (bus.imem_ack) state_d = FETCH;
      end
      default: ;
    endcase
    if (bus.redirect_valid) ps = PS_LOAD;
  end

  assign bus.ps        = ps;
  assign bus.pc_in     = bus.redirect_valid ? bus.redirect_target : 32'h0;
  assign bus.imem_req  = req;
  assign bus.imem_addr = addr;
  assign bus.if_valid  = !q_empty;
  assign bus.if_instr  = q_head.instr;
  assign bus.if_pc     = q_head.pc;
  assign bus.if_pc_4   = q_head.pc + 32'd4;
  assign dbg_state_o   = state_q;
  assign dbg_count_o   = q_count;

endmodule
